// File: rtl/replay_ctrl_pkg.sv
// Shared types and constants for the stage-8 replay controller.
package replay_ctrl_pkg;

  // Pipeline stage at which ops commit or are replayed.
  localparam int unsigned S8_STAGE = 8;

  typedef enum logic {
    RUN      = 1'b0,
    THROTTLE = 1'b1
  } replay_ctrl_state_t;

endpackage : replay_ctrl_pkg

// File: rtl/credit_pool.sv
// Reusable downstream credit counter with a sticky overflow error.
module credit_pool #(
  parameter int unsigned NCREDITS = 4,
  parameter int unsigned CW       = $clog2(NCREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          take_i,
  input  logic          give_i,
  output logic [CW-1:0] cnt_o,
  output logic          err_o
);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Count = count - take + give. A return into a full pool is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CW'(NCREDITS);
      err_q <= 1'b0;
    end else if (give_i && !take_i) begin
      if (cnt_q == CW'(NCREDITS)) begin
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (take_i && !give_i) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule : credit_pool

// File: rtl/replay_ctrl.sv
// Stage-8 commit/replay decision, replay statistics and front-end throttle.
module replay_ctrl
  import replay_ctrl_pkg::*;
#(
  parameter int unsigned N             = 10,
  parameter int unsigned NCREDITS      = 4,
  parameter int unsigned MAX_REPLAY    = 3,
  parameter int unsigned RESUME_THRESH = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s8_adv,
  input  logic                           credit_ret,
  output logic                           replay_s8_w,
  output logic                           commit_s8,
  output logic [N-1:0]                   stall_req,
  output logic [$clog2(NCREDITS+1)-1:0]  credit_cnt_r,
  output logic [CNT_W-1:0]               replay_cnt_r,
  output logic                           throttle_r,
  output logic                           err_r
);

  localparam int unsigned CW     = $clog2(NCREDITS + 1);
  localparam int unsigned CONS_W = $clog2(MAX_REPLAY + 1);

  replay_ctrl_state_t  state_q;
  logic                replay_q;
  logic [CONS_W-1:0]   cons_q;
  logic [CONS_W-1:0]   cons_d;
  logic [CNT_W-1:0]    replay_cnt_q;
  logic [N-1:0]        stall_q;
  logic                throttle_q;
  logic                live_c;

  // Decisions use only registered state, so credit_ret never reaches them combinationally.
  always_comb begin
    live_c      = s8_adv & ~replay_q;
    commit_s8   = live_c & (credit_cnt_r != '0);
    replay_s8_w = live_c & (credit_cnt_r == '0);
    cons_d      = cons_q;
    if (commit_s8) begin
      cons_d = '0;
    end else if (replay_s8_w && cons_q != CONS_W'(MAX_REPLAY)) begin
      cons_d = cons_q + CONS_W'(1);
    end
  end

  credit_pool #(
    .NCREDITS (NCREDITS),
    .CW       (CW)
  ) u_credit_pool (
    .clk    (clk),
    .rst    (rst),
    .take_i (commit_s8),
    .give_i (credit_ret),
    .cnt_o  (credit_cnt_r),
    .err_o  (err_r)
  );

  // Local copy of the pipeline's registered replay: marks the kill/shadow cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q <= 1'b0;
    end else begin
      replay_q <= replay_s8_w;
    end
  end

  // Saturating total replay count.
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_cnt_q <= '0;
    end else if (replay_s8_w && replay_cnt_q != '1) begin
      replay_cnt_q <= replay_cnt_q + CNT_W'(1);
    end
  end

  // Throttle FSM with registered stall and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      throttle_q <= 1'b0;
      stall_q    <= '0;
      cons_q     <= '0;
    end else begin
      case (state_q)
        RUN: begin
          cons_q <= cons_d;
          if (replay_s8_w && cons_q == CONS_W'(MAX_REPLAY - 1)) begin
            state_q    <= THROTTLE;
            throttle_q <= 1'b1;
            stall_q    <= N'(1);
          end
        end
        THROTTLE: begin
          if (credit_cnt_r >= CW'(RESUME_THRESH)) begin
            state_q    <= RUN;
            throttle_q <= 1'b0;
            stall_q    <= '0;
            cons_q     <= '0;
          end else begin
            cons_q <= cons_d;
          end
        end
        default: begin
          state_q    <= RUN;
          throttle_q <= 1'b0;
          stall_q    <= '0;
          cons_q     <= '0;
        end
      endcase
    end
  end

  assign replay_cnt_r = replay_cnt_q;
  assign stall_req    = stall_q;
  assign throttle_r   = throttle_q;

endmodule : replay_ctrl

// File: tb/tb_replay_ctrl.sv
// Directed + randomized bench for replay_ctrl against a behavioural model.
module tb_replay_ctrl;

  localparam int unsigned N             = 10;
  localparam int unsigned NCREDITS      = 4;
  localparam int unsigned MAX_REPLAY    = 3;
  localparam int unsigned RESUME_THRESH = 2;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned CW            = $clog2(NCREDITS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s8_adv = 1'b0;
  logic             credit_ret = 1'b0;
  logic             replay_s8_w;
  logic             commit_s8;
  logic [N-1:0]     stall_req;
  logic [CW-1:0]    credit_cnt_r;
  logic [CNT_W-1:0] replay_cnt_r;
  logic             throttle_r;
  logic             err_r;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_credits;
  int m_replays;
  int m_consec;
  bit m_throttle;
  bit m_err;
  bit m_shadow;
  bit checking = 1'b0;

  replay_ctrl #(
    .N             (N),
    .NCREDITS      (NCREDITS),
    .MAX_REPLAY    (MAX_REPLAY),
    .RESUME_THRESH (RESUME_THRESH),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s8_adv       (s8_adv),
    .credit_ret   (credit_ret),
    .replay_s8_w  (replay_s8_w),
    .commit_s8    (commit_s8),
    .stall_req    (stall_req),
    .credit_cnt_r (credit_cnt_r),
    .replay_cnt_r (replay_cnt_r),
    .throttle_r   (throttle_r),
    .err_r        (err_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credits  = NCREDITS;
    m_replays  = 0;
    m_consec   = 0;
    m_throttle = 1'b0;
    m_err      = 1'b0;
    m_shadow   = 1'b0;
  endtask

  // One clock cycle: drive, check against model, clock, advance model.
  task automatic step(input bit a, input bit r, input bit rs);
    bit live, m_commit, m_replay, enter, leave;
    @(negedge clk);
    s8_adv     = a;
    credit_ret = r;
    rst        = rs;
    #1;
    live     = a && !m_shadow;
    m_commit = live && (m_credits > 0);
    m_replay = live && (m_credits == 0);
    if (checking) begin
      check("commit_s8",    64'(commit_s8),    64'(m_commit));
      check("replay_s8_w",  64'(replay_s8_w),  64'(m_replay));
      check("credit_cnt_r", 64'(credit_cnt_r), 64'(m_credits));
      check("replay_cnt_r", 64'(replay_cnt_r), 64'(m_replays));
      check("throttle_r",   64'(throttle_r),   64'(m_throttle));
      check("stall_req",    64'(stall_req),    64'(m_throttle));
      check("err_r",        64'(err_r),        64'(m_err));
    end
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      leave = m_throttle && (m_credits >= RESUME_THRESH);
      enter = !m_throttle && m_replay && (m_consec == MAX_REPLAY - 1);
      if (m_commit || leave) m_consec = 0;
      else if (m_replay && m_consec < MAX_REPLAY) m_consec++;
      if (enter) m_throttle = 1'b1;
      else if (leave) m_throttle = 1'b0;
      m_credits = m_credits - int'(m_commit) + int'(r);
      if (m_credits > NCREDITS) begin
        m_credits = NCREDITS;
        m_err     = 1'b1;
      end
      if (m_replay && m_replays < (2 ** CNT_W) - 1) m_replays++;
      m_shadow = m_replay;
    end
  endtask

  // Fixed-value check of registered outputs just after the clock edge.
  task automatic expect_now(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check(tag, obs, exp);
  endtask

  initial begin
    model_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    checking = 1'b1;
    #1;
    expect_now("rst_credit",   64'(credit_cnt_r), 64'(4));
    expect_now("rst_stall",    64'(stall_req),    64'(0));
    expect_now("rst_replays",  64'(replay_cnt_r), 64'(0));

    // Four separated commits drain the pool
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    #1;
    expect_now("drain_credit", 64'(credit_cnt_r), 64'(0));
    expect_now("drain_replays", 64'(replay_cnt_r), 64'(0));

    // Replay then shadow; three replays in total enter THROTTLE
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #1;
    expect_now("first_replay_cnt", 64'(replay_cnt_r), 64'(1));
    expect_now("first_throttle",   64'(throttle_r),   64'(0));
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #1;
    expect_now("thr_enter",    64'(throttle_r),   64'(1));
    expect_now("thr_stall",    64'(stall_req),    64'(1));
    expect_now("thr_replays",  64'(replay_cnt_r), 64'(3));

    // Two returns reach the resume threshold, exit one cycle later
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #1;
    expect_now("resume_credit", 64'(credit_cnt_r), 64'(2));
    expect_now("resume_still",  64'(throttle_r),   64'(1));
    step(1'b0, 1'b0, 1'b0);
    #1;
    expect_now("resume_exit",  64'(throttle_r), 64'(0));
    expect_now("resume_stall", 64'(stall_req),  64'(0));

    // Simultaneous commit and return at one credit
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #1;
    expect_now("cr_same_cycle", 64'(credit_cnt_r), 64'(1));

    // Overflow at full pool is sticky
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #1;
    expect_now("ovf_credit", 64'(credit_cnt_r), 64'(4));
    expect_now("ovf_err",    64'(err_r),        64'(1));
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #1;
    expect_now("ovf_sticky", 64'(err_r), 64'(1));

    // Reach THROTTLE with empty pool, then reset
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    #1;
    expect_now("pre_rst_thr", 64'(throttle_r),   64'(1));
    expect_now("pre_rst_cr",  64'(credit_cnt_r), 64'(0));
    step(1'b1, 1'b0, 1'b1);
    #1;
    expect_now("mid_rst_credit",  64'(credit_cnt_r), 64'(4));
    expect_now("mid_rst_stall",   64'(stall_req),    64'(0));
    expect_now("mid_rst_thr",     64'(throttle_r),   64'(0));
    expect_now("mid_rst_replays", 64'(replay_cnt_r), 64'(0));
    expect_now("mid_rst_err",     64'(err_r),        64'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 299) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_replay_ctrl
